// File: rtl/fifo_txuart.sv
// Buffered 8N1 UART transmitter: strobe/busy write port into a 2^LGFIFO-byte FIFO,
// drained back-to-back by a baud-rate serializer (start, 8 data bits LSB first, stop).
module fifo_txuart #(
  parameter logic [23:0] CLOCKS_PER_BAUD = 24'd868,
  parameter int          LGFIFO          = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_wr,
  input  logic [7:0]        i_data,
  output logic              o_busy,
  output logic [LGFIFO:0]   o_fill,
  output logic              o_idle,
  output logic              o_uart_tx
);

  localparam int              DEPTH  = 1 << LGFIFO;
  localparam logic [LGFIFO:0] FULL   = (LGFIFO+1)'(DEPTH);
  localparam logic [LGFIFO:0] ONE    = (LGFIFO+1)'(1);
  localparam logic [LGFIFO-1:0] PONE = LGFIFO'(1);
  localparam logic [23:0]     CPB_M1 = CLOCKS_PER_BAUD - 24'd1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]      mem [0:DEPTH-1];
  logic [LGFIFO:0] wr_ptr, rd_ptr, fill, fill_n;
  state_t          state, state_n;
  logic [23:0]     baud_cnt, baud_cnt_n;
  logic [3:0]      bit_idx, bit_idx_n;
  logic [7:0]      shreg, shreg_n;
  logic            tx_n, pop, wr_en;

  // Busy is the registered full flag, so a write is refused when full even if a pop coincides.
  assign wr_en  = i_wr && !o_busy;
  assign o_fill = fill;

  always_comb begin
    fill_n = fill;
    case ({wr_en, pop})
      2'b10:   fill_n = fill + ONE;
      2'b01:   fill_n = fill - ONE;
      default: fill_n = fill;
    endcase
  end

  always_comb begin
    state_n    = state;
    baud_cnt_n = (baud_cnt == 24'd0) ? 24'd0 : baud_cnt - 24'd1;
    bit_idx_n  = bit_idx;
    shreg_n    = shreg;
    tx_n       = o_uart_tx;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (fill != '0) begin
          pop        = 1'b1;
          shreg_n    = mem[rd_ptr[LGFIFO-1:0]];
          tx_n       = 1'b0;
          baud_cnt_n = CPB_M1;
          state_n    = START;
        end
      end
      START: begin
        if (baud_cnt == 24'd0) begin
          tx_n       = shreg[0];
          shreg_n    = {1'b0, shreg[7:1]};
          bit_idx_n  = 4'd0;
          baud_cnt_n = CPB_M1;
          state_n    = DATA;
        end
      end
      DATA: begin
        if (baud_cnt == 24'd0) begin
          baud_cnt_n = CPB_M1;
          if (bit_idx == 4'd7) begin
            tx_n    = 1'b1;
            state_n = STOP;
          end else begin
            tx_n      = shreg[0];
            shreg_n   = {1'b0, shreg[7:1]};
            bit_idx_n = bit_idx + 4'd1;
          end
        end
      end
      STOP: begin
        // Chain straight into the next start bit so frames run back-to-back.
        if (baud_cnt == 24'd0) begin
          if (fill != '0) begin
            pop        = 1'b1;
            shreg_n    = mem[rd_ptr[LGFIFO-1:0]];
            tx_n       = 1'b0;
            baud_cnt_n = CPB_M1;
            state_n    = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (wr_en)
      mem[wr_ptr[LGFIFO-1:0]] <= i_data;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state     <= IDLE;
      baud_cnt  <= 24'd0;
      bit_idx   <= 4'd0;
      shreg     <= 8'd0;
      o_uart_tx <= 1'b1;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fill      <= '0;
      o_busy    <= 1'b0;
      o_idle    <= 1'b1;
    end else begin
      state     <= state_n;
      baud_cnt  <= baud_cnt_n;
      bit_idx   <= bit_idx_n;
      shreg     <= shreg_n;
      o_uart_tx <= tx_n;
      fill      <= fill_n;
      o_busy    <= (fill_n == FULL);
      o_idle    <= (state_n == IDLE) && (fill_n == '0);
      if (wr_en)
        wr_ptr <= {1'b0, wr_ptr[LGFIFO-1:0] + PONE};
      if (pop)
        rd_ptr <= {1'b0, rd_ptr[LGFIFO-1:0] + PONE};
    end
  end

endmodule
